fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//  Fetch-stage PC generator and instruction-bus requester. It accepts branch/jump redirects
//  (PCSel/pc_address) resolved in decode and drives the F->D pipeline register. It holds the
//  ibus request stable until data_ok and discards wrong-path returns after a redirect.
//  It supplies decode with the fetched instr, its PC and the predicted successor
//  (the PC decode compares its resolved target against).
// PARAMETERS
//  PC_RESET  64'h8000_0000  first fetch address after reset
// PORTS
//  clk            in   1   clock; single clock domain
//  reset          in   1   asynchronous, active-high reset
//  redirect       in   1   PCSel from decode: flush and refetch from redirect_pc
//  redirect_pc    in   64  pc_address from decode
//  stall          in   1   decode cannot accept the F->D register this cycle
//  ireq_valid     out  1   instruction-bus request valid
//  ireq_addr      out  64  instruction-bus request address
//  iresp_data_ok  in   1   instruction-bus data return strobe
//  iresp_data     in   32  returned instruction word
//  f_valid        out  1   F->D register holds a live instruction
//  f_pc           out  64  PC of f_instr
//  f_instr        out  32  raw instruction
//  f_next_pc      out  64  predicted successor = f_pc + 4; decode compares it as last_pc
// BEHAVIOUR
//  - Reset (async, any state): pc_q=PC_RESET, state=IDLE, f_valid=0, f_pc=0, f_instr=0,
//    pend_q=0. ireq_valid=0 while reset is high and during IDLE.
//  - States: IDLE, WAIT (request outstanding), DROP (outstanding request is wrong-path),
//    HOLD (instr in F->D register, awaiting decode).
//  - ireq_valid=1 in WAIT and DROP only. ireq_addr=pc_q. Address is stable from assertion
//    until the data_ok cycle.
//  - IDLE -> WAIT unconditionally, one cycle after reset deasserts.
//  - WAIT, data_ok=1, redirect=0: f_valid<=1, f_pc<=pc_q, f_instr<=iresp_data; -> HOLD.
//  - WAIT, data_ok=1, redirect=1: data discarded; pc_q<=redirect_pc; stay WAIT.
//    The new request is issued next cycle.
//  - WAIT, data_ok=0, redirect=1: pend_q<=redirect_pc; -> DROP.
//    The bus request cannot be aborted.
//  - DROP, redirect=1: pend_q<=redirect_pc (latest wins). DROP+data_ok: data discarded;
//    pc_q<=pend_q, or redirect_pc if redirect is high that same cycle; -> WAIT.
//  - HOLD: no bus request. redirect=1 (priority over stall): f_valid<=0,
//    pc_q<=redirect_pc, -> WAIT.
//    redirect=0, stall=0: decode takes the instr this edge; f_valid<=0, pc_q<=pc_q+4, -> WAIT.
//    stall=1: F->D register and pc_q hold.
//  - Any redirect clears f_valid at the next edge, so no wrong-path instr reaches decode.
//  - f_valid is never 1 in WAIT/DROP. Throughput is 1 instr per bus latency + 1 cycle.
//  - Arithmetic: pc_q+4 and f_pc+4 are modulo 2^64 (wrap 64'hFFFF_FFFF_FFFF_FFFC -> 0).
//    redirect_pc is used verbatim; alignment is decode's responsibility.
//  - Reset mid-request: state returns to IDLE. A data_ok from the pre-reset request that
//    arrives in IDLE is ignored.
// STRUCTURE
//  - fetch_state_t enum (IDLE/WAIT/DROP/HOLD) in pipes.
//  - PC_RESET default constant in common, shared with the CSR/trap path.
//  - Single module: one always_ff for state, pc_q, pend_q and the F->D register,
//    one always_comb for the bus drive. No sub-module warranted.
// TESTING
//  1 Reset release, data_ok 2 cycles later, data=32'h00000013 -> ireq_addr=80000000;
//    then f_valid=1, f_pc=80000000, f_next_pc=80000004.
//  2 HOLD with stall=1 for 3 cycles -> f_* stable, ireq_valid=0.
//    stall drops -> next request addr=80000004.
//  3 redirect=1 to 80000100 in WAIT, data_ok 2 cycles later -> that data dropped, f_valid
//    stays 0, next ireq_addr=80000100.
//  4 redirect to 0x200 then 0x300 during DROP -> refetch addr=0x300.
//    redirect coincident with data_ok -> addr=redirect_pc.
//  5 redirect + stall together in HOLD -> f_valid=0 next cycle, fetch from redirect_pc.
//  6 Assert reset while in DROP, pulse data_ok in IDLE -> no f_valid.
//    First request is at PC_RESET.
//    Wrap case: pc_q=FFFF_FFFF_FFFF_FFFC, HOLD released -> next addr=0.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller.
// Reset PC is common with the CSR/trap path.
package fetch_pc_ctrl_pkg;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;
    localparam logic [63:0] INSTR_BYTES      = 64'd4;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DROP,
        FS_HOLD
    } fetch_state_t;

    function automatic logic [63:0] seq_pc(input logic [63:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC generator and instruction-bus requester.
// Drives the F->D register and drops wrong-path bus returns.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr,
    output logic [63:0] f_next_pc
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [63:0]  pc_q;
    logic [63:0]  pend_q;
    logic         f_valid_q;
    logic [63:0]  f_pc_q;
    logic [31:0]  f_instr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FS_IDLE;
            pc_q      <= PC_RESET;
            pend_q    <= '0;
            f_valid_q <= 1'b0;
            f_pc_q    <= '0;
            f_instr_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FS_WAIT: begin
                    if (iresp_data_ok) begin
                        if (redirect) begin
                            pc_q <= redirect_pc;
                        end else begin
                            f_valid_q <= 1'b1;
                            f_pc_q    <= pc_q;
                            f_instr_q <= iresp_data;
                        end
                    end else if (redirect) begin
                        pend_q <= redirect_pc;
                    end
                end
                // The bus cannot abort, so the latest target waits in pend_q.
                FS_DROP: begin
                    if (iresp_data_ok) begin
                        pc_q <= redirect ? redirect_pc : pend_q;
                    end else if (redirect) begin
                        pend_q <= redirect_pc;
                    end
                end
                FS_HOLD: begin
                    if (redirect) begin
                        f_valid_q <= 1'b0;
                        pc_q      <= redirect_pc;
                    end else if (!stall) begin
                        f_valid_q <= 1'b0;
                        pc_q      <= seq_pc(pc_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE: state_d = FS_WAIT;
            FS_WAIT: begin
                if (iresp_data_ok && !redirect) begin
                    state_d = FS_HOLD;
                end else if (!iresp_data_ok && redirect) begin
                    state_d = FS_DROP;
                end
            end
            FS_DROP: begin
                if (iresp_data_ok) begin
                    state_d = FS_WAIT;
                end
            end
            FS_HOLD: begin
                if (redirect || !stall) begin
                    state_d = FS_WAIT;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_comb begin
        ireq_valid = (state_q == FS_WAIT) || (state_q == FS_DROP);
        ireq_addr  = pc_q;
        f_valid    = f_valid_q;
        f_pc       = f_pc_q;
        f_instr    = f_instr_q;
        f_next_pc  = seq_pc(f_pc_q);
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed scenarios then random
// redirect/stall/bus-latency traffic against an instruction-stream model.
module tb_fetch_pc_ctrl;

    localparam logic [63:0] PC_RST = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        f_valid;
    logic [63:0] f_pc;
    logic [31:0] f_instr;
    logic [63:0] f_next_pc;

    int checks = 0;
    int failures = 0;

    logic [63:0] req_q[$];
    logic [95:0] del_q[$];

    // Instruction-stream model: target is the PC the stream is at.
    bit          m_idle;
    bit          m_busy;
    bit          m_wrong;
    bit          m_held;
    logic [63:0] m_target;

    fetch_pc_ctrl dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .ireq_valid(ireq_valid),
        .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .f_valid(f_valid),
        .f_pc(f_pc),
        .f_instr(f_instr),
        .f_next_pc(f_next_pc)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic r, input logic [63:0] rpc,
                         input logic st, input logic dok,
                         input logic [31:0] d);
        redirect      = r;
        redirect_pc   = rpc;
        stall         = st;
        iresp_data_ok = dok;
        iresp_data    = d;
        if (m_idle) begin
            m_idle  = 0;
            m_busy  = 1;
            m_wrong = 0;
            req_q.push_back(m_target);
        end else if (m_busy) begin
            if (r) m_target = rpc;
            if (dok) begin
                if (m_wrong || r) begin
                    m_wrong = 0;
                    req_q.push_back(m_target);
                end else begin
                    m_busy = 0;
                    m_held = 1;
                    del_q.push_back({m_target, d});
                end
            end else if (r) begin
                m_wrong = 1;
            end
        end else if (m_held) begin
            if (r) begin
                m_target = rpc;
                m_held   = 0;
                m_busy   = 1;
                req_q.push_back(m_target);
            end else if (!st) begin
                m_target = m_target + 64'd4;
                m_held   = 0;
                m_busy   = 1;
                req_q.push_back(m_target);
            end
        end
    endtask

    task automatic step(input logic r, input logic [63:0] rpc,
                        input logic st, input logic dok,
                        input logic [31:0] d);
        @(negedge clk);
        apply(r, rpc, st, dok, d);
    endtask

    task automatic do_reset(input logic dok_on_release);
        @(negedge clk);
        reset         = 1'b1;
        redirect      = 1'b0;
        stall         = 1'b0;
        iresp_data_ok = 1'b0;
        m_idle   = 1;
        m_busy   = 0;
        m_wrong  = 0;
        m_held   = 0;
        m_target = PC_RST;
        req_q.delete();
        del_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        apply(1'b0, 64'd0, 1'b0, dok_on_release, 32'hDEAD_BEEF);
    endtask

    // Monitor: samples just after each rising edge.
    bit          prev_v;
    bit          prev_f;
    logic [63:0] prev_addr;
    logic [63:0] prev_fpc;
    logic [31:0] prev_finstr;

    initial begin
        logic [63:0] ea;
        logic [95:0] ed;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                checks++;
                if (ireq_valid !== 1'b0 || f_valid !== 1'b0 ||
                    f_pc !== 64'd0 || f_instr !== 32'd0) begin
                    failures++;
                    $display("FAIL reset_outs got v=%b fv=%b pc=%h ins=%h req 0", ireq_valid, f_valid, f_pc, f_instr);
                end
                prev_v = 0;
                prev_f = 0;
            end else begin
                checks++;
                if (ireq_valid === 1'b1 && f_valid === 1'b1) begin
                    failures++;
                    $display("FAIL req_and_fvalid got both high req exclusive");
                end
                if (ireq_valid === 1'b1 && (!prev_v || iresp_data_ok)) begin
                    checks++;
                    if (req_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_req got addr=%h required none", ireq_addr);
                    end else begin
                        ea = req_q.pop_front();
                        if (ireq_addr !== ea) begin
                            failures++;
                            $display("FAIL req_addr got=%h required=%h", ireq_addr, ea);
                        end
                    end
                end else if (ireq_valid === 1'b1 && prev_v) begin
                    checks++;
                    if (ireq_addr !== prev_addr) begin
                        failures++;
                        $display("FAIL req_stable got=%h required=%h", ireq_addr, prev_addr);
                    end
                end
                if (f_valid === 1'b1 && !prev_f) begin
                    checks++;
                    if (del_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_instr got pc=%h required none", f_pc);
                    end else begin
                        ed = del_q.pop_front();
                        if (f_pc !== ed[95:32] || f_instr !== ed[31:0] ||
                            f_next_pc !== ed[95:32] + 64'd4) begin
                            failures++;
                            $display("FAIL deliver got pc=%h ins=%h npc=%h required pc=%h ins=%h npc=%h",
                                     f_pc, f_instr, f_next_pc, ed[95:32], ed[31:0], ed[95:32] + 64'd4);
                        end
                    end
                end else if (f_valid === 1'b1 && prev_f) begin
                    checks++;
                    if (f_pc !== prev_fpc || f_instr !== prev_finstr) begin
                        failures++;
                        $display("FAIL hold_stable got pc=%h ins=%h required pc=%h ins=%h",
                                 f_pc, f_instr, prev_fpc, prev_finstr);
                    end
                end
                prev_v = (ireq_valid === 1'b1);
                prev_f = (f_valid === 1'b1);
            end
            prev_addr   = ireq_addr;
            prev_fpc    = f_pc;
            prev_finstr = f_instr;
        end
    end

    initial begin
        logic [63:0] rpc;
        logic        r;
        m_idle   = 1;
        m_busy   = 0;
        m_wrong  = 0;
        m_held   = 0;
        m_target = PC_RST;

        // Reset release, data two cycles later, stall in HOLD, release.
        do_reset(1'b0);
        step(0, 64'd0, 0, 0, 32'd0);
        step(0, 64'd0, 0, 1, 32'h0000_0013);
        step(0, 64'd0, 1, 0, 32'd0);
        step(0, 64'd0, 1, 0, 32'd0);
        step(0, 64'd0, 1, 0, 32'd0);
        step(0, 64'd0, 0, 0, 32'd0);

        // Redirect in WAIT, stale data dropped.
        step(1, 64'h8000_0100, 0, 0, 32'd0);
        step(0, 64'd0, 0, 0, 32'd0);
        step(0, 64'd0, 0, 1, 32'hBAD0_0001);
        step(0, 64'd0, 0, 1, 32'h1111_0001);

        // Redirect with stall in HOLD.
        step(1, 64'h8000_0500, 1, 0, 32'd0);

        // Two redirects during DROP, then redirect coincident with data_ok.
        step(1, 64'h200, 0, 0, 32'd0);
        step(1, 64'h300, 0, 0, 32'd0);
        step(0, 64'd0, 0, 1, 32'hBAD0_0002);
        step(1, 64'h400, 0, 1, 32'hBAD0_0003);
        step(0, 64'd0, 0, 1, 32'h2222_0002);
        step(0, 64'd0, 0, 0, 32'd0);

        // PC wrap at the top of the address space.
        step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 32'hBAD0_0004);
        step(0, 64'd0, 0, 1, 32'h3333_0003);
        step(0, 64'd0, 0, 0, 32'd0);
        step(0, 64'd0, 0, 1, 32'h4444_0004);

        // Reset while DROP; stale data_ok in IDLE is ignored.
        step(0, 64'd0, 0, 0, 32'd0);
        step(1, 64'h700, 0, 0, 32'd0);
        do_reset(1'b1);
        step(0, 64'd0, 0, 0, 32'd0);
        step(0, 64'd0, 0, 1, 32'h5555_0005);
        step(0, 64'd0, 0, 0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 800 == 799) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                r = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0)
                    rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'({$urandom_range(0, 3), 2'b00});
                else
                    rpc = {$urandom(), $urandom()} & ~64'h3;
                step(r, rpc, $urandom_range(0, 1) == 1,
                     m_busy && ($urandom_range(0, 2) == 0), $urandom());
            end
        end

        @(negedge clk);
        redirect      = 1'b0;
        iresp_data_ok = 1'b0;
        stall         = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (req_q.size() != 0 || del_q.size() != 0) begin
            failures++;
            $display("FAIL drain got req=%0d del=%0d pending required 0", req_q.size(), del_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
